mpm_code_loader: RTL

- Upstream stage of the MPM CPU. Receives a program as a serial nibble stream over a 3-wire SPI-like link (scs_n, sclk, sdata).
- Writes each nibble into the 256x4 code RAM starting at address 0, while holding the CPU in its stop state.
- Optionally issues the one-cycle run pulse that starts the CPU once the frame ends.
- Owns the code RAM write port. The CPU's code_add drives the RAM read port only when the loader is idle.

---
 rtl/mpm_code_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mpm_code_loader.sv
// MPM code loader: serial nibble stream into the code RAM,
// holding the CPU in reset while loading and optionally starting it.
module mpm_code_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_RUN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scs_n,
  input  logic              sclk,
  input  logic              sdata,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              cpu_run,
  output logic [ADDR_W:0]   nib_count,
  output logic [7:0]        checksum,
  output logic              frame_err
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, WRITE, FINISH, RUN
  } state_t;

  state_t state_q;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] ck_sync_q;
  logic [SYNC_STAGES-1:0] dt_sync_q;
  logic cs_s, ck_s, dt_s;

  // Edge-detect stage: cs_q and dat_q are delayed to line up with rise_q.
  logic ck_prev_q, rise_q, dat_q, cs_q;

  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [ADDR_W-1:0] add_q;
  logic [DATA_W-1:0] din_q;
  logic              we_q, hold_q, run_q, err_q;
  logic [ADDR_W:0]   nib_q;
  logic [7:0]        cks_q;
  logic [DATA_W-1:0] nib_d;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign ck_s  = ck_sync_q[SYNC_STAGES-1];
  assign dt_s  = dt_sync_q[SYNC_STAGES-1];
  assign nib_d = {shift_q[DATA_W-2:0], dat_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q <= '1;
      ck_sync_q <= '0;
      dt_sync_q <= '0;
      ck_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      dat_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], scs_n};
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], sclk};
      dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], sdata};
      ck_prev_q <= ck_s;
      rise_q    <= ck_s & ~ck_prev_q;
      dat_q     <= dt_s;
      cs_q      <= cs_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      add_q   <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      nib_q   <= '0;
      cks_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q <= 1'b0;
          run_q  <= 1'b0;
          if (!cs_q) begin
            nib_q   <= '0;
            cks_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            add_q   <= '0;
            hold_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_q && cnt_q == LAST) begin
            shift_q <= nib_d;
            cnt_q   <= '0;
            // RAM already full: consume the nibble but do not write it.
            if (nib_q[ADDR_W]) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= 1'b1;
              din_q   <= nib_d;
              state_q <= WRITE;
            end
          end else if (cs_q) begin
            if (cnt_q != '0) err_q <= 1'b1;
            state_q <= FINISH;
          end else if (rise_q) begin
            shift_q <= nib_d;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          add_q   <= add_q + 1'b1;
          nib_q   <= nib_q + 1'b1;
          cks_q   <= cks_q + 8'(din_q);
          state_q <= SHIFT;
        end
        FINISH: begin
          hold_q <= 1'b0;
          if (AUTO_RUN && !err_q && nib_q != '0) begin
            run_q   <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          run_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_add   = add_q;
  assign ram_din   = din_q;
  assign ram_we    = we_q;
  assign cpu_hold  = hold_q;
  assign cpu_run   = run_q;
  assign nib_count = nib_q;
  assign checksum  = cks_q;
  assign frame_err = err_q;

endmodule
